// File: rtl/ddr3_vga_pkg.sv
// Shared types and frame geometry for the DDR3 -> VGA read path.
package ddr3_vga_pkg;

  localparam int H_ACTIVE         = 1280;
  localparam int V_ACTIVE         = 720;
  localparam int PIX_PER_WORD     = 4;
  localparam int SEG_PER_LINE     = 8;
  localparam int LINE_WORDS       = H_ACTIVE / PIX_PER_WORD;
  localparam int SEG_WORDS        = LINE_WORDS / SEG_PER_LINE;
  localparam int FRAME_WORDS_DFLT = LINE_WORDS * V_ACTIVE;
  localparam int CMD_LEN_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } rd_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; when empty, dout keeps the last
// popped word (cleared by flush or reset).
module sync_fifo_fwft #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 128
) (
  input  logic                       vga_clk,
  input  logic                       vga_rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [WIDTH-1:0]           dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] last_q;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign wr_ok = push & ~full & ~flush;
  assign rd_ok = pop & ~empty & ~flush;

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  assign count = cnt;
  assign dout  = empty ? last_q : mem[rd_ptr];

endmodule

// File: rtl/ddr3_vga_rd_buf.sv
// DDR3 frame-buffer read stage feeding the VGA display: burst command issue,
// beat capture into a FWFT FIFO, frame address wrap and restart/flush.
//
// state    | meaning
// ST_IDLE  | wait for a pending request and room for a whole burst
// ST_CMD   | cmd_valid_o held with a stable address until accepted
// ST_DATA  | capturing the burst beats into the FIFO
// ST_DRAIN | restart hit mid-burst; remaining beats counted and discarded
module ddr3_vga_rd_buf
  import ddr3_vga_pkg::*;
#(
  parameter int BURST_WORDS = SEG_WORDS,
  parameter int FRAME_WORDS = FRAME_WORDS_DFLT,
  parameter int FRAME_BASE  = 0,
  parameter int ADDR_W      = 28,
  parameter int FIFO_DEPTH  = 128,
  parameter int PEND_MAX    = 15
) (
  input  logic                 vga_clk_i,
  input  logic                 vga_rst_n_i,
  input  logic                 ddr3_rd_addr_rst_i,
  input  logic                 ddr3_rd_req_i,
  input  logic                 ddr3_rd_en_i,
  output logic [63:0]          ddr3_data_vga_o,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [ADDR_W-1:0]    cmd_addr_o,
  output logic [CMD_LEN_W-1:0] cmd_len_o,
  input  logic                 rdata_valid_i,
  input  logic [63:0]          rdata_i,
  output logic [7:0]           fifo_cnt_o,
  output logic                 underflow_o,
  output logic                 overflow_o
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PEND_W = $clog2(PEND_MAX + 1);
  localparam int BEAT_W = $clog2(BURST_WORDS + 1);
  localparam logic [ADDR_W:0] FRAME_END = (ADDR_W+1)'(FRAME_BASE + FRAME_WORDS);

  rd_state_t         state_q;
  rd_state_t         state_d;
  logic [PEND_W-1:0] pend_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] inflight;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W-1:0] addr_nxt;
  logic              under_q;
  logic              over_q;

  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;

  logic              cmd_acc;
  logic              req_eff;
  logic              acc_eff;
  logic              last_beat;
  logic              pend_sat;
  logic              room_ok;
  logic              beat_slot;

  // A restart in the same cycle cancels both a new request and an accept.
  assign cmd_acc   = (state_q == ST_CMD) & cmd_ready_i;
  assign req_eff   = ddr3_rd_req_i & ~ddr3_rd_addr_rst_i;
  assign acc_eff   = cmd_acc & ~ddr3_rd_addr_rst_i;
  assign beat_slot = (state_q == ST_DATA) | (state_q == ST_DRAIN);
  assign last_beat = beat_slot & rdata_valid_i & (beat_q == BEAT_W'(1));
  assign pend_sat  = (pend_q == PEND_W'(PEND_MAX));
  assign fifo_push = (state_q == ST_DATA) & rdata_valid_i & ~ddr3_rd_addr_rst_i;

  // Beats still owed to the current burst already have FIFO space reserved.
  assign inflight = (state_q == ST_DATA) ? beat_q : '0;
  assign room_ok  = (int'(fifo_cnt) + int'(inflight) + BURST_WORDS) <= FIFO_DEPTH;

  assign addr_sum = {1'b0, addr_q} + (ADDR_W+1)'(BURST_WORDS);
  assign addr_nxt = (addr_sum >= FRAME_END) ? ADDR_W'(FRAME_BASE) : addr_sum[ADDR_W-1:0];

  always_comb begin
    state_d     = state_q;
    cmd_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ddr3_rd_addr_rst_i && (pend_q != '0) && room_ok) state_d = ST_CMD;
      end
      ST_CMD: begin
        cmd_valid_o = 1'b1;
        if (ddr3_rd_addr_rst_i)  state_d = ST_IDLE;
        else if (cmd_ready_i)    state_d = ST_DATA;
      end
      ST_DATA: begin
        if (last_beat)               state_d = ST_IDLE;
        else if (ddr3_rd_addr_rst_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_beat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk_i or negedge vga_rst_n_i) begin
    if (!vga_rst_n_i) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_ff @(posedge vga_clk_i or negedge vga_rst_n_i) begin
    if (!vga_rst_n_i) begin
      pend_q <= '0;
    end else if (ddr3_rd_addr_rst_i) begin
      pend_q <= '0;
    end else if (req_eff && !acc_eff && !pend_sat) begin
      pend_q <= pend_q + 1'b1;
    end else if (acc_eff && !req_eff) begin
      pend_q <= pend_q - 1'b1;
    end
  end

  // Beat counter keeps running through a restart so DRAIN knows when to stop.
  always_ff @(posedge vga_clk_i or negedge vga_rst_n_i) begin
    if (!vga_rst_n_i) begin
      beat_q <= '0;
    end else if (acc_eff) begin
      beat_q <= BEAT_W'(BURST_WORDS);
    end else if (beat_slot && rdata_valid_i && (beat_q != '0)) begin
      beat_q <= beat_q - 1'b1;
    end
  end

  always_ff @(posedge vga_clk_i or negedge vga_rst_n_i) begin
    if (!vga_rst_n_i)            addr_q <= ADDR_W'(FRAME_BASE);
    else if (ddr3_rd_addr_rst_i) addr_q <= ADDR_W'(FRAME_BASE);
    else if (acc_eff)            addr_q <= addr_nxt;
  end

  always_ff @(posedge vga_clk_i or negedge vga_rst_n_i) begin
    if (!vga_rst_n_i) begin
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      if (ddr3_rd_en_i && fifo_empty) under_q <= 1'b1;
      if ((req_eff && !acc_eff && pend_sat) || (fifo_push && fifo_full)) over_q <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .vga_clk   (vga_clk_i),
    .vga_rst_n (vga_rst_n_i),
    .push      (fifo_push),
    .din       (rdata_i),
    .pop       (ddr3_rd_en_i),
    .flush     (ddr3_rd_addr_rst_i),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dout      (ddr3_data_vga_o)
  );

  assign cmd_addr_o  = addr_q;
  assign cmd_len_o   = CMD_LEN_W'(BURST_WORDS);
  assign fifo_cnt_o  = 8'(fifo_cnt);
  assign underflow_o = under_q;
  assign overflow_o  = over_q;

endmodule

// File: tb/tb_ddr3_vga_rd_buf.sv
// Directed bench for ddr3_vga_rd_buf: burst issue, FWFT reads, backpressure,
// frame wrap, restart/drain, pend saturation and async reset.
module tb_ddr3_vga_rd_buf;

  logic        vga_clk_i = 1'b0;
  logic        vga_rst_n_i;
  logic        ddr3_rd_addr_rst_i;
  logic        ddr3_rd_req_i;
  logic        ddr3_rd_en_i;
  logic [63:0] ddr3_data_vga_o;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [27:0] cmd_addr_o;
  logic [7:0]  cmd_len_o;
  logic        rdata_valid_i;
  logic [63:0] rdata_i;
  logic [7:0]  fifo_cnt_o;
  logic        underflow_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;
  int unsigned max_cnt = 0;
  bit seen;

  // Short frame (10 bursts) so the address wrap is reached quickly.
  ddr3_vga_rd_buf #(.FRAME_WORDS(400)) dut (
    .vga_clk_i          (vga_clk_i),
    .vga_rst_n_i        (vga_rst_n_i),
    .ddr3_rd_addr_rst_i (ddr3_rd_addr_rst_i),
    .ddr3_rd_req_i      (ddr3_rd_req_i),
    .ddr3_rd_en_i       (ddr3_rd_en_i),
    .ddr3_data_vga_o    (ddr3_data_vga_o),
    .cmd_valid_o        (cmd_valid_o),
    .cmd_ready_i        (cmd_ready_i),
    .cmd_addr_o         (cmd_addr_o),
    .cmd_len_o          (cmd_len_o),
    .rdata_valid_i      (rdata_valid_i),
    .rdata_i            (rdata_i),
    .fifo_cnt_o         (fifo_cnt_o),
    .underflow_o        (underflow_o),
    .overflow_o         (overflow_o)
  );

  always #5 vga_clk_i = ~vga_clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge vga_clk_i);
    if (fifo_cnt_o > max_cnt) max_cnt = fifo_cnt_o;
  endtask

  task automatic wait_cmd(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (cmd_valid_o) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic send_beats(input int n, input logic [63:0] base, input bit with_pop);
    for (int i = 0; i < n; i++) begin
      rdata_valid_i = 1'b1;
      rdata_i       = base + 64'(i);
      ddr3_rd_en_i  = with_pop;
      step();
    end
    rdata_valid_i = 1'b0;
    ddr3_rd_en_i  = 1'b0;
  endtask

  task automatic pop_n(input int n);
    ddr3_rd_en_i = 1'b1;
    repeat (n) step();
    ddr3_rd_en_i = 1'b0;
  endtask

  task automatic pulse_req();
    ddr3_rd_req_i = 1'b1;
    step();
    ddr3_rd_req_i = 1'b0;
  endtask

  task automatic pulse_addr_rst();
    ddr3_rd_addr_rst_i = 1'b1;
    step();
    ddr3_rd_addr_rst_i = 1'b0;
  endtask

  initial begin
    vga_rst_n_i = 1'b0; ddr3_rd_addr_rst_i = 1'b0; ddr3_rd_req_i = 1'b0;
    ddr3_rd_en_i = 1'b0; cmd_ready_i = 1'b0; rdata_valid_i = 1'b0; rdata_i = '0;
    step(); step();
    chk("rst_cmd_valid", cmd_valid_o, 0);
    chk("rst_addr", cmd_addr_o, 0);
    chk("rst_data", ddr3_data_vga_o, 0);
    chk("rst_cnt", fifo_cnt_o, 0);
    chk("rst_under", underflow_o, 0);
    chk("rst_over", overflow_o, 0);
    vga_rst_n_i = 1'b1;
    step();

    // single burst
    cmd_ready_i = 1'b1;
    pulse_req();
    wait_cmd(10, seen);
    chk("t1_cmd_seen", seen, 1);
    chk("t1_addr", cmd_addr_o, 0);
    chk("t1_len", cmd_len_o, 40);
    step();
    chk("t1_valid_one_cycle", cmd_valid_o, 0);
    send_beats(40, 64'd0, 1'b0);
    chk("t1_cnt", fifo_cnt_o, 40);
    chk("t1_head", ddr3_data_vga_o, 0);

    // slow pops, then one extra
    for (int i = 0; i < 40; i++) begin
      chk("t2_pop_data", ddr3_data_vga_o, 64'(i));
      pop_n(1);
      step(); step(); step();
    end
    chk("t2_cnt_empty", fifo_cnt_o, 0);
    chk("t2_no_under", underflow_o, 0);
    chk("t2_hold_last", ddr3_data_vga_o, 39);
    pop_n(1);
    step();
    chk("t2_under", underflow_o, 1);
    chk("t2_hold_after_under", ddr3_data_vga_o, 39);

    // restart in IDLE
    pulse_addr_rst();
    chk("t3_rst_addr", cmd_addr_o, 0);
    chk("t3_rst_data", ddr3_data_vga_o, 0);

    // 8 requests under backpressure, FIFO space gating
    cmd_ready_i = 1'b0;
    ddr3_rd_req_i = 1'b1;
    repeat (8) step();
    ddr3_rd_req_i = 1'b0;
    repeat (20) step();
    chk("t3_held_valid", cmd_valid_o, 1);
    chk("t3_held_addr", cmd_addr_o, 0);
    cmd_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        repeat (5) step();
        chk("t3_gate_120", cmd_valid_o, 0);
        chk("t3_cnt_120", fifo_cnt_o, 120);
        pop_n(31);
        repeat (3) step();
        chk("t3_gate_89", cmd_valid_o, 0);
        chk("t3_cnt_89", fifo_cnt_o, 89);
        chk("t3_head_31", ddr3_data_vga_o, 31);
        pop_n(1);
        chk("t3_head_32", ddr3_data_vga_o, 32);
      end
      wait_cmd(20, seen);
      chk("t3_cmd_seen", seen, 1);
      chk("t3_addr", cmd_addr_o, 64'(40 * k));
      step();
      send_beats(40, 64'(k * 256), k >= 3);
    end
    wait_cmd(10, seen);
    chk("t3_pend_exhausted", seen, 0);
    chk("t3_cnt_end", fifo_cnt_o, 88);
    chk("t3_max_cnt", 64'(max_cnt), 120);
    chk("t3_no_over", overflow_o, 0);

    // frame wrap
    pulse_addr_rst();
    chk("t4_flush_cnt", fifo_cnt_o, 0);
    for (int k = 0; k < 10; k++) begin
      pulse_req();
      wait_cmd(10, seen);
      chk("t4_cmd_seen", seen, 1);
      chk("t4_addr", cmd_addr_o, 64'(40 * k));
      step();
      send_beats(40, 64'(k * 256), 1'b0);
      pop_n(40);
    end
    pulse_req();
    wait_cmd(10, seen);
    chk("t4_wrap_seen", seen, 1);
    chk("t4_wrap_addr", cmd_addr_o, 0);
    step();

    // restart after 10 of 40 beats
    send_beats(10, 64'h100, 1'b0);
    chk("t5_cnt_10", fifo_cnt_o, 10);
    pulse_addr_rst();
    chk("t5_flush_cnt", fifo_cnt_o, 0);
    chk("t5_flush_data", ddr3_data_vga_o, 0);
    send_beats(30, 64'h200, 1'b0);
    chk("t5_drain_cnt", fifo_cnt_o, 0);
    chk("t5_drain_no_cmd", cmd_valid_o, 0);
    pulse_req();
    wait_cmd(10, seen);
    chk("t5_cmd_seen", seen, 1);
    chk("t5_addr", cmd_addr_o, 0);
    step();
    send_beats(40, 64'h500, 1'b0);
    chk("t5_first_word", ddr3_data_vga_o, 64'h500);
    chk("t5_cnt_40", fifo_cnt_o, 40);

    // restart and request together
    ddr3_rd_addr_rst_i = 1'b1;
    ddr3_rd_req_i = 1'b1;
    step();
    ddr3_rd_addr_rst_i = 1'b0;
    ddr3_rd_req_i = 1'b0;
    wait_cmd(10, seen);
    chk("t6_req_dropped", seen, 0);
    chk("t6_cnt", fifo_cnt_o, 0);

    // pend saturation
    cmd_ready_i = 1'b0;
    ddr3_rd_req_i = 1'b1;
    repeat (15) step();
    ddr3_rd_req_i = 1'b0;
    step();
    chk("t7_pend15_no_over", overflow_o, 0);
    pulse_req();
    chk("t7_sat_over", overflow_o, 1);
    chk("t7_cmd_waiting", cmd_valid_o, 1);
    pulse_addr_rst();
    chk("t7_rst_drops_valid", cmd_valid_o, 0);
    wait_cmd(10, seen);
    chk("t7_pend_cleared", seen, 0);

    // async reset mid-DATA
    cmd_ready_i = 1'b1;
    pulse_req();
    wait_cmd(10, seen);
    chk("t8_cmd_seen", seen, 1);
    step();
    send_beats(5, 64'hA0, 1'b0);
    chk("t8_cnt_5", fifo_cnt_o, 5);
    chk("t8_head", ddr3_data_vga_o, 64'hA0);
    chk("t8_addr_adv", cmd_addr_o, 40);
    #2 vga_rst_n_i = 1'b0;
    #1;
    chk("t8_async_cnt", fifo_cnt_o, 0);
    chk("t8_async_data", ddr3_data_vga_o, 0);
    chk("t8_async_addr", cmd_addr_o, 0);
    chk("t8_async_valid", cmd_valid_o, 0);
    chk("t8_async_under", underflow_o, 0);
    chk("t8_async_over", overflow_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
